pipe_stage_skid: RTL

Parametrised pipeline stage register, the successor to the fixed-width F→D stage register. It moves one instruction beat (instr, pc, exception code, branch-delay flag) per cycle using valid/ready handshakes on both sides. A two-entry skid buffer keeps `in_ready` registered, so stall no longer propagates combinationally. Exception entry (`req`) and flush (`clr`) are handled inside the block. The block sits between any two pipeline stages (F/D, D/E, E/M, M/W).

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_entry.sv | 70 +++++++
 rtl/pipe_stage_skid.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the skid-buffered pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy of the stage: main entry only, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned DEFAULT_INSTR_W = 32;
  localparam int unsigned DEFAULT_PC_W    = 32;
  localparam int unsigned DEFAULT_EXC_W   = 5;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [DEFAULT_INSTR_W-1:0] instr;
    logic [DEFAULT_PC_W-1:0]    pc;
    logic [DEFAULT_EXC_W-1:0]   exc;
    logic                       bd;
  } pipe_beat_t;

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry
// Brief    : One payload register with load-enable and bubble injection.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned EXC_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [INSTR_W-1:0] ld_instr,
  input  logic [PC_W-1:0]    ld_pc,
  input  logic [EXC_W-1:0]   ld_exc,
  input  logic               ld_bd,
  input  logic               ld_bubble,
  input  logic               inject,
  input  logic               inject_pc_sel,
  input  logic [PC_W-1:0]    inject_pc,
  output logic [INSTR_W-1:0] q_instr,
  output logic [PC_W-1:0]    q_pc,
  output logic [EXC_W-1:0]   q_exc,
  output logic               q_bd,
  output logic               q_bubble
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [EXC_W-1:0]   r_exc;
  logic               r_bd;
  logic               r_bubble;

  // Injection outranks load; without inject_pc_sel the PC is left as-is.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr  <= '0;
      r_pc     <= '0;
      r_exc    <= '0;
      r_bd     <= 1'b0;
      r_bubble <= 1'b0;
    end else if (inject) begin
      r_instr  <= '0;
      r_exc    <= EXC_W'(EXC_NONE);
      r_bd     <= 1'b0;
      r_bubble <= 1'b1;
      if (inject_pc_sel) begin
        r_pc <= inject_pc;
      end
    end else if (load) begin
      r_instr  <= ld_instr;
      r_pc     <= ld_pc;
      r_exc    <= ld_exc;
      r_bd     <= ld_bd;
      r_bubble <= ld_bubble;
    end
  end

  assign q_instr  = r_instr;
  assign q_pc     = r_pc;
  assign q_exc    = r_exc;
  assign q_bd     = r_bd;
  assign q_bubble = r_bubble;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Valid/ready pipeline stage with two-entry skid buffer and
//            exception-entry / flush bubble injection.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned     INSTR_W    = 32,
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     EXC_W      = 5,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(HANDLER_PC_DEFAULT),
  parameter int unsigned     PC_INC     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [PC_W-1:0]    out_pc8,
  output logic               out_bubble
);

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;
  logic        r_in_ready;

  logic w_in_fire;
  logic w_out_fire;
  logic w_out_valid;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_main_load;
  logic w_skid_load;
  logic w_inject;

  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc;
  logic [EXC_W-1:0]   w_skid_exc;
  logic               w_skid_bd;
  logic               w_skid_bubble;

  logic [INSTR_W-1:0] w_main_ld_instr;
  logic [PC_W-1:0]    w_main_ld_pc;
  logic [EXC_W-1:0]   w_main_ld_exc;
  logic               w_main_ld_bd;
  logic               w_main_ld_bubble;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;
  assign w_inject    = req | clr;

  // Main refills from the input when it is free this cycle, from skid when
  // draining out of TWO; skid only captures while main is still occupied.
  assign w_main_from_in   = w_in_fire & ((r_state == EMPTY) | ((r_state == ONE) & w_out_fire));
  assign w_main_from_skid = (r_state == TWO) & w_out_fire;
  assign w_main_load      = w_main_from_in | w_main_from_skid;
  assign w_skid_load      = (r_state == ONE) & w_in_fire & ~w_out_fire;

  assign w_main_ld_instr  = w_main_from_skid ? w_skid_instr  : in_instr;
  assign w_main_ld_pc     = w_main_from_skid ? w_skid_pc     : in_pc;
  assign w_main_ld_exc    = w_main_from_skid ? w_skid_exc    : in_exc;
  assign w_main_ld_bd     = w_main_from_skid ? w_skid_bd     : in_bd;
  assign w_main_ld_bubble = w_main_from_skid ? w_skid_bubble : 1'b0;

  always_comb begin
    w_state_nxt = r_state;
    if (req) begin
      w_state_nxt = ONE;
    end else if (clr) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) w_state_nxt = ONE;
        ONE: begin
          if (w_in_fire && !w_out_fire) begin
            w_state_nxt = TWO;
          end else if (!w_in_fire && w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO:     if (w_out_fire) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next occupancy, keeping stall off any
  // combinational path back to upstream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  pipe_entry #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .EXC_W   (EXC_W)
  ) u_main (
    .clk           (clk),
    .reset         (reset),
    .load          (w_main_load),
    .ld_instr      (w_main_ld_instr),
    .ld_pc         (w_main_ld_pc),
    .ld_exc        (w_main_ld_exc),
    .ld_bd         (w_main_ld_bd),
    .ld_bubble     (w_main_ld_bubble),
    .inject        (w_inject),
    .inject_pc_sel (req),
    .inject_pc     (HANDLER_PC),
    .q_instr       (out_instr),
    .q_pc          (out_pc),
    .q_exc         (out_exc),
    .q_bd          (out_bd),
    .q_bubble      (out_bubble)
  );

  pipe_entry #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .EXC_W   (EXC_W)
  ) u_skid (
    .clk           (clk),
    .reset         (reset),
    .load          (w_skid_load),
    .ld_instr      (in_instr),
    .ld_pc         (in_pc),
    .ld_exc        (in_exc),
    .ld_bd         (in_bd),
    .ld_bubble     (1'b0),
    .inject        (w_inject),
    .inject_pc_sel (1'b0),
    .inject_pc     ('0),
    .q_instr       (w_skid_instr),
    .q_pc          (w_skid_pc),
    .q_exc         (w_skid_exc),
    .q_bd          (w_skid_bd),
    .q_bubble      (w_skid_bubble)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_pc8   = out_pc + PC_W'(PC_INC);

endmodule
`default_nettype wire
